// File: rtl/com_pkg.sv
// Shared definitions for the command controller: btype codes, data_cmd field
// positions and the controller state encoding.
package com_pkg;

    localparam logic [3:0] BAG_INIT   = 4'h0;
    localparam logic [3:0] BAG_ACK    = 4'h1;
    localparam logic [3:0] BAG_NAK    = 4'h2;
    localparam logic [3:0] BAG_STL    = 4'h3;
    localparam logic [3:0] BAG_DIDX   = 4'h5;
    localparam logic [3:0] BAG_DPARAM = 4'h6;
    localparam logic [3:0] BAG_DDIDX  = 4'h7;
    localparam logic [3:0] BAG_ERROR  = 4'hF;

    localparam int DEV_LSB   = 28;
    localparam int DEV_MSB   = 31;
    localparam int DIDX_LSB  = 24;
    localparam int DIDX_MSB  = 27;
    localparam int PADDR_LSB = 20;
    localparam int PADDR_MSB = 23;
    localparam int PBYTE_LSB = 12;
    localparam int PBYTE_MSB = 19;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_LTCH, ST_DEC, ST_TXRQ, ST_RELS
    } state_e;

    typedef enum logic [1:0] {
        APPLY_NONE, APPLY_DEV, APPLY_DATA, APPLY_PARAM
    } apply_e;

endpackage

// File: rtl/com_ctrl_dec.sv
// Combinational packet classifier: maps a latched btype and the config-busy
// flag to the reply type, which register to update and the error flag.
module com_ctrl_dec
    import com_pkg::*;
(
    input  logic [3:0] btype,
    input  logic       cfg_busy,
    output logic [3:0] resp,
    output logic [1:0] apply,
    output logic       skip_reply,
    output logic       is_err
);

    always_comb begin
        resp       = BAG_NAK;
        apply      = APPLY_NONE;
        skip_reply = 1'b0;
        is_err     = 1'b0;
        case (btype)
            BAG_DIDX, BAG_DDIDX, BAG_DPARAM: begin
                if (cfg_busy) begin
                    resp = BAG_STL;
                end else begin
                    resp = BAG_ACK;
                    case (btype)
                        BAG_DIDX:  apply = APPLY_DEV;
                        BAG_DDIDX: apply = APPLY_DATA;
                        default:   apply = APPLY_PARAM;
                    endcase
                end
            end
            // Host replies are terminal; nothing goes back to the host.
            BAG_ACK, BAG_NAK, BAG_STL: skip_reply = 1'b1;
            default: is_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/com_ctrl.sv
// Command controller: consumes decoded packets, updates config registers and
// requests the reply. Optional TXRQ timeout enabled by COM_CTRL_TIMEOUT_EN.
module com_ctrl
    import com_pkg::*;
#(
`ifdef COM_CTRL_TIMEOUT_EN
    parameter logic [15:0] TX_TIMEOUT = 16'd1024,
`endif
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_fs,
    output logic             rx_fd,
    input  logic [3:0]       rx_btype,
    input  logic [31:0]      rx_data_cmd,
    input  logic             cfg_busy,
    output logic [3:0]       device_idx,
    output logic [3:0]       data_idx,
    output logic [3:0]       dparam_addr,
    output logic [7:0]       dparam_data,
    output logic             dparam_we,
    output logic             tx_fs,
    output logic [3:0]       tx_btype,
    input  logic             tx_fd,
    output logic [ERR_W-1:0] err_cnt
);

    state_e state_q, state_d;
    logic [3:0] btype_q, btype_d, dev_l_q, dev_l_d, didx_l_q, didx_l_d, paddr_l_q, paddr_l_d;
    logic [7:0] pbyte_l_q, pbyte_l_d;
    logic [3:0] resp_q, resp_d;
    logic       skip_q, skip_d;
    logic [3:0] device_idx_q, device_idx_d, data_idx_q, data_idx_d;
    logic [3:0] dparam_addr_q, dparam_addr_d;
    logic [7:0] dparam_data_q, dparam_data_d;
    logic       dparam_we_q, dparam_we_d, tx_fs_q, tx_fs_d, rx_fd_q, rx_fd_d;
    logic [3:0] tx_btype_q, tx_btype_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d, err_inc;
`ifdef COM_CTRL_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
`endif

    logic [3:0] dec_resp;
    logic [1:0] dec_apply;
    logic       dec_skip, dec_err;
    logic       unused_cmd_bits;

    assign unused_cmd_bits = ^rx_data_cmd[PBYTE_LSB-1:0];

    com_ctrl_dec u_dec (
        .btype      (btype_q),
        .cfg_busy   (cfg_busy),
        .resp       (dec_resp),
        .apply      (dec_apply),
        .skip_reply (dec_skip),
        .is_err     (dec_err)
    );

    assign err_inc = (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q : err_cnt_q + 1'b1;

    // The decision is taken on the edge into DEC so the strobe and register
    // updates are visible during DEC and the reply can go out as DEC ends.
    always_comb begin
        state_d       = state_q;
        btype_d       = btype_q;
        dev_l_d       = dev_l_q;
        didx_l_d      = didx_l_q;
        paddr_l_d     = paddr_l_q;
        pbyte_l_d     = pbyte_l_q;
        resp_d        = resp_q;
        skip_d        = skip_q;
        device_idx_d  = device_idx_q;
        data_idx_d    = data_idx_q;
        dparam_addr_d = dparam_addr_q;
        dparam_data_d = dparam_data_q;
        dparam_we_d   = 1'b0;
        tx_fs_d       = tx_fs_q;
        tx_btype_d    = tx_btype_q;
        rx_fd_d       = rx_fd_q;
        err_cnt_d     = err_cnt_q;
`ifdef COM_CTRL_TIMEOUT_EN
        tmo_d         = tmo_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (rx_fs) begin
                    state_d   = ST_LTCH;
                    btype_d   = rx_btype;
                    dev_l_d   = rx_data_cmd[DEV_MSB:DEV_LSB];
                    didx_l_d  = rx_data_cmd[DIDX_MSB:DIDX_LSB];
                    paddr_l_d = rx_data_cmd[PADDR_MSB:PADDR_LSB];
                    pbyte_l_d = rx_data_cmd[PBYTE_MSB:PBYTE_LSB];
                end
            end
            ST_LTCH: begin
                state_d = ST_DEC;
                resp_d  = dec_resp;
                skip_d  = dec_skip;
                case (dec_apply)
                    APPLY_DEV:  device_idx_d = dev_l_q;
                    APPLY_DATA: data_idx_d   = didx_l_q;
                    APPLY_PARAM: begin
                        dparam_we_d   = 1'b1;
                        dparam_addr_d = paddr_l_q;
                        dparam_data_d = pbyte_l_q;
                    end
                    default: ;
                endcase
                if (dec_err) err_cnt_d = err_inc;
            end
            ST_DEC: begin
                if (skip_q) begin
                    state_d = ST_RELS;
                end else begin
                    state_d    = ST_TXRQ;
                    tx_fs_d    = 1'b1;
                    tx_btype_d = resp_q;
`ifdef COM_CTRL_TIMEOUT_EN
                    tmo_d      = 16'd0;
`endif
                end
            end
            ST_TXRQ: begin
                if (tx_fd) begin
                    state_d    = ST_RELS;
                    tx_fs_d    = 1'b0;
                    tx_btype_d = 4'h0;
`ifdef COM_CTRL_TIMEOUT_EN
                end else if (tmo_q == TX_TIMEOUT - 16'd1) begin
                    state_d    = ST_RELS;
                    tx_fs_d    = 1'b0;
                    tx_btype_d = 4'h0;
                    err_cnt_d  = err_inc;
                end else begin
                    tmo_d = tmo_q + 16'd1;
`endif
                end
            end
            ST_RELS: begin
                if (!rx_fs) begin
                    state_d = ST_WAIT;
                    rx_fd_d = 1'b0;
                end else begin
                    rx_fd_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            btype_q       <= 4'h0;
            dev_l_q       <= 4'h0;
            didx_l_q      <= 4'h0;
            paddr_l_q     <= 4'h0;
            pbyte_l_q     <= 8'h0;
            resp_q        <= 4'h0;
            skip_q        <= 1'b0;
            device_idx_q  <= 4'h0;
            data_idx_q    <= 4'h0;
            dparam_addr_q <= 4'h0;
            dparam_data_q <= 8'h0;
            dparam_we_q   <= 1'b0;
            tx_fs_q       <= 1'b0;
            tx_btype_q    <= 4'h0;
            rx_fd_q       <= 1'b0;
            err_cnt_q     <= '0;
`ifdef COM_CTRL_TIMEOUT_EN
            tmo_q         <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            btype_q       <= btype_d;
            dev_l_q       <= dev_l_d;
            didx_l_q      <= didx_l_d;
            paddr_l_q     <= paddr_l_d;
            pbyte_l_q     <= pbyte_l_d;
            resp_q        <= resp_d;
            skip_q        <= skip_d;
            device_idx_q  <= device_idx_d;
            data_idx_q    <= data_idx_d;
            dparam_addr_q <= dparam_addr_d;
            dparam_data_q <= dparam_data_d;
            dparam_we_q   <= dparam_we_d;
            tx_fs_q       <= tx_fs_d;
            tx_btype_q    <= tx_btype_d;
            rx_fd_q       <= rx_fd_d;
            err_cnt_q     <= err_cnt_d;
`ifdef COM_CTRL_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign rx_fd       = rx_fd_q;
    assign device_idx  = device_idx_q;
    assign data_idx    = data_idx_q;
    assign dparam_addr = dparam_addr_q;
    assign dparam_data = dparam_data_q;
    assign dparam_we   = dparam_we_q;
    assign tx_fs       = tx_fs_q;
    assign tx_btype    = tx_btype_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_com_ctrl.sv
// Directed bench for com_ctrl: drives packets over the rx handshake, plays the
// transmitter, and checks register effects, reply types and handshake timing.
module tb_com_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_fs = 1'b0;
    logic        rx_fd;
    logic [3:0]  rx_btype = 4'h0;
    logic [31:0] rx_data_cmd = 32'h0;
    logic        cfg_busy = 1'b0;
    logic [3:0]  device_idx, data_idx, dparam_addr;
    logic [7:0]  dparam_data;
    logic        dparam_we;
    logic        tx_fs;
    logic [3:0]  tx_btype;
    logic        tx_fd = 1'b0;
    logic [7:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int r_tx_c, r_rx_c, r_we_n, r_we_c, r_tx_len, r_done, r_order;
    logic [3:0] r_tx_bt, r_we_a;
    logic [7:0] r_we_d;

    always #5 clk = ~clk;

    com_ctrl #(
`ifdef COM_CTRL_TIMEOUT_EN
        .TX_TIMEOUT(16'd16),
`endif
        .ERR_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_fs(rx_fs), .rx_fd(rx_fd), .rx_btype(rx_btype), .rx_data_cmd(rx_data_cmd),
        .cfg_busy(cfg_busy),
        .device_idx(device_idx), .data_idx(data_idx),
        .dparam_addr(dparam_addr), .dparam_data(dparam_data), .dparam_we(dparam_we),
        .tx_fs(tx_fs), .tx_btype(tx_btype), .tx_fd(tx_fd),
        .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Cycle c counts negedges after rx_fs is raised; the transmitter answers
    // tx_delay cycles after it first sees tx_fs.
    task automatic send(input logic [3:0] bt, input logic [31:0] cmd, input logic busy,
                        input int tx_delay);
        r_tx_c = -1; r_rx_c = -1; r_we_n = 0; r_we_c = -1; r_tx_len = 0;
        r_done = 0; r_order = 1; r_tx_bt = 4'h0; r_we_a = 4'h0; r_we_d = 8'h0;
        @(negedge clk);
        rx_btype = bt; rx_data_cmd = cmd; cfg_busy = busy; rx_fs = 1'b1;
        for (int c = 1; c <= 400 && r_done == 0; c++) begin
            @(negedge clk);
            if (dparam_we) begin
                r_we_n++; r_we_c = c; r_we_a = dparam_addr; r_we_d = dparam_data;
            end
            if (tx_fs) begin
                if (r_tx_c < 0) begin r_tx_c = c; r_tx_bt = tx_btype; end
                r_tx_len++;
                if (c - r_tx_c >= tx_delay) tx_fd = 1'b1;
            end else begin
                tx_fd = 1'b0;
            end
            if (rx_fd && r_rx_c < 0) begin
                r_rx_c = c;
                if (tx_fs) r_order = 0;
                rx_fs = 1'b0;
            end
            if (r_rx_c >= 0 && !rx_fd) r_done = 1;
        end
        tx_fd = 1'b0;
        chk({"done_", $sformatf("%0h", bt)}, r_done, 1);
    endtask

    task automatic chk_reply(input string tag, input logic [3:0] resp, input int tx_delay);
        chk({tag, "_tx_lat"}, r_tx_c, 3);
        chk({tag, "_tx_bt"}, r_tx_bt, resp);
        chk({tag, "_rx_fd_lat"}, r_rx_c, 3 + tx_delay + 2);
        chk({tag, "_order"}, r_order, 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rx_fd", rx_fd, 0);
        chk("rst_tx_fs", tx_fs, 0);
        chk("rst_regs", {device_idx, data_idx, dparam_addr, dparam_data, tx_btype}, 0);
        chk("rst_we", dparam_we, 0);
        chk("rst_err", err_cnt, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(4'h5, 32'h7000_0000, 1'b0, 0);
        chk_reply("didx", 4'h1, 0);
        chk("didx_dev", device_idx, 4'h7);
        chk("didx_we", r_we_n, 0);

        send(4'h6, 32'h0035_A000, 1'b0, 0);
        chk_reply("dparam", 4'h1, 0);
        chk("dparam_we_n", r_we_n, 1);
        chk("dparam_we_lat", r_we_c, 2);
        chk("dparam_addr", r_we_a, 4'h3);
        chk("dparam_data", r_we_d, 8'h5A);
        chk("dparam_dev_kept", device_idx, 4'h7);

        send(4'h7, 32'h0500_0000, 1'b0, 1);
        chk_reply("ddidx", 4'h1, 1);
        chk("ddidx_data", data_idx, 4'h5);

        send(4'h7, 32'h0900_0000, 1'b1, 0);
        chk_reply("ddidx_busy", 4'h3, 0);
        chk("ddidx_busy_data", data_idx, 4'h5);
        chk("ddidx_busy_err", err_cnt, 0);

        send(4'h6, 32'h00F1_2000, 1'b1, 0);
        chk_reply("dparam_busy", 4'h3, 0);
        chk("dparam_busy_we", r_we_n, 0);

        send(4'h5, 32'h3000_0000, 1'b0, 4);
        chk_reply("didx_slow", 4'h1, 4);
        chk("didx_slow_dev", device_idx, 4'h3);

        // Host replies: no reply, rx_fd one cycle after entering RELS
        for (int b = 1; b <= 3; b++) begin
            send(b[3:0], 32'hFFFF_FFFF, 1'b0, 0);
            chk($sformatf("host%0d_no_tx", b), r_tx_c, -1);
            chk($sformatf("host%0d_rx_fd", b), r_rx_c, 4);
            chk($sformatf("host%0d_regs", b), {device_idx, data_idx}, 8'h35);
        end
        chk("host_err", err_cnt, 0);

        send(4'h0, 32'h0, 1'b0, 0);
        chk_reply("init", 4'h2, 0);
        chk("init_err", err_cnt, 1);

        send(4'h4, 32'h0, 1'b0, 0);
        chk_reply("undef", 4'h2, 0);
        chk("undef_err", err_cnt, 2);

        send(4'hF, 32'h0, 1'b1, 0);
        chk_reply("error", 4'h2, 0);
        chk("error_err", err_cnt, 3);

        // 300 more ERROR packets: NAK every time, counter pins at FF
        for (int i = 0; i < 300; i++) begin
            send(4'hF, 32'h0, 1'b0, 0);
            chk("sat_tx_bt", r_tx_bt, 4'h2);
            if (i == 251) chk("sat_reach", err_cnt, 8'hFF);
        end
        chk("sat_final", err_cnt, 8'hFF);

`ifdef COM_CTRL_TIMEOUT_EN
        send(4'h5, 32'h1000_0000, 1'b0, 100000);
        chk("tmo_tx_lat", r_tx_c, 3);
        chk("tmo_tx_len", r_tx_len, 16);
        chk("tmo_rx_fd", r_rx_c, 20);
        chk("tmo_err_sat", err_cnt, 8'hFF);
`endif

        // Reset mid-packet, while the reply request is up
        @(negedge clk);
        rx_btype = 4'h5; rx_data_cmd = 32'hC000_0000; cfg_busy = 1'b0; rx_fs = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_tx_fs", tx_fs, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_fs", tx_fs, 0);
        chk("mid_rst_rx_fd", rx_fd, 0);
        chk("mid_rst_regs", {device_idx, data_idx, err_cnt}, 0);
        rx_fs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(4'h5, 32'h9000_0000, 1'b0, 0);
        chk_reply("post_rst", 4'h1, 0);
        chk("post_rst_dev", device_idx, 4'h9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
